sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters: the video framebuffer fetch (burst reads, deadline-critical) and the CPU (single-word read/write).
- Sits in the clk_sdram domain, between the CPU/video clock-crossing logic and the SDRAM controller.
- Video has fixed priority, with a starvation limit that guarantees CPU progress.

Parameters:
ADDR_W, 22, word address width.
DATA_W, 32, data word width.
BURST_LEN, 8, words per video burst (power of two, 2..256).
CPU_MAX_WAIT, 16, cycles CPU may wait before forced grant (1..255).

Ports:
clk_sdram  in  1  100 MHz SDRAM controller clock; all logic rising-edge.
rst_n  in  1  asynchronous active-low reset.
vid_req  in  1  level; burst read request.
vid_addr  in  ADDR_W  burst start address; stable while vid_req is high.
vid_ack  out  1  1-cycle pulse; burst accepted by controller.
vid_rvalid  out  1  burst word valid.
vid_rdata  out  DATA_W  burst word.
vid_done  out  1  1-cycle pulse with last word.
cpu_req  in  1  level; held until cpu_ack.
cpu_we  in  1  1 = write.
cpu_addr  in  ADDR_W  word address.
cpu_wdata  in  DATA_W  write data.
cpu_be  in  DATA_W/8  byte enables.
cpu_ack  out  1  1-cycle pulse; transfer complete; cpu_rdata valid on reads.
cpu_rdata  out  DATA_W  read data, held until next cpu_ack.
mem_req  out  1  request to controller.
mem_we  out  1  write.
mem_burst  out  1  1 = BURST_LEN read, 0 = single word.
mem_addr  out  ADDR_W  address.
mem_wdata  out  DATA_W  write data.
mem_be  out  DATA_W/8  byte enables (all ones for bursts).
mem_gnt  in  1  1-cycle accept of mem_req.
mem_rvalid  in  1  read word valid.
mem_rdata  in  DATA_W  read word.
mem_wdone  in  1  write complete pulse.

Behaviour:
- Reset: every output is 0, FSM is IDLE, wait counter and beat counter are 0.
- States are IDLE, ISSUE, CPU_WAIT, VID_STREAM and DONE.
- IDLE arbitration:
  - Video wins if vid_req is high and (cpu_req is low or wait_cnt < CPU_MAX_WAIT).
  - Otherwise CPU wins if cpu_req is high.
  - The winner's address, data, be, we and burst are registered. Next state is ISSUE.
  - Latency: a request seen in IDLE at cycle N gives mem_req=1 at N+1.
- ISSUE:
  - mem_req and the registered fields are held stable until the mem_gnt cycle. mem_req drops the cycle after mem_gnt.
  - On mem_gnt: video pulses vid_ack and goes to VID_STREAM; CPU goes to CPU_WAIT.
- CPU_WAIT:
  - A read completes on the first mem_rvalid; mem_rdata is latched into cpu_rdata.
  - A write completes on mem_wdone.
  - Completion pulses cpu_ack the next cycle, then goes to DONE.
- VID_STREAM:
  - Each mem_rvalid is forwarded to vid_rvalid/vid_rdata with 1 registered cycle of latency.
  - The beat counter counts to BURST_LEN. vid_done is asserted together with the last vid_rvalid. Then goes to DONE.
- DONE: one cycle, requests ignored (lets requesters drop req after ack). Then IDLE.
- wait_cnt:
  - Increments each cycle cpu_req is high and the CPU is not the current owner; saturates at CPU_MAX_WAIT.
  - Clears when the CPU wins arbitration.
- mem_rvalid or mem_wdone outside CPU_WAIT/VID_STREAM: ignored.
- mem_gnt outside ISSUE: ignored.
- cpu_req dropped while the CPU owns the port: the transfer completes and cpu_ack still pulses.
- vid_req dropped while video owns the port: the burst completes.
- rst_n low mid-operation: outputs clear immediately, in-flight data is discarded. The controller shares rst_n, so it is reset together.

Optional Feature:
- Macro: SDRAM_ARB_STATS_EN.
- When defined, adds two ports:
  - stat_vid_bursts out 16: increments on each vid_done.
  - stat_cpu_forced out 16: increments when the CPU wins IDLE arbitration while vid_req is also high.
  - Both counters saturate at 0xFFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. CPU read alone: cpu_addr=0x000123, mem_gnt 2 cycles after mem_req, mem_rvalid with 0xDEADBEEF 3 cycles later -> mem_we=0, mem_burst=0, one cpu_ack pulse with cpu_rdata=0xDEADBEEF.
2. CPU write cpu_be=4'b0011, cpu_wdata=0x12345678 -> mem_we=1, mem_be=4'b0011, mem_wdata=0x12345678; cpu_ack the cycle after mem_wdone.
3. vid_req and cpu_req rise the same cycle -> video issued first with mem_burst=1; 8 vid_rvalid words equal to mem_rdata 0..7; vid_done on word 8; DONE; then the CPU transfer is issued.
4. Starvation: vid_req and cpu_req held continuously, CPU_MAX_WAIT=16 -> once wait_cnt saturates at 16, the next IDLE grants the CPU; stat_cpu_forced=1 (with macro); video resumes afterwards.
5. rst_n low after the 3rd burst word -> all outputs 0 asynchronously; after release, a fresh CPU read completes normally with no stray vid_rvalid.
6. Spurious mem_rvalid in IDLE -> no vid_rvalid, no cpu_ack, state unchanged.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-way SDRAM port arbiter: video bursts (fixed priority) vs CPU single words; SDRAM_ARB_STATS_EN adds usage counters.
// Latency: IDLE request -> mem_req next cycle; requesters hold req until ack, controller stalls the issue via mem_gnt.
module sdram_port_arbiter #(
    parameter int ADDR_W       = 22,
    parameter int DATA_W       = 32,
    parameter int BURST_LEN    = 8,
    parameter int CPU_MAX_WAIT = 16
) (
    input  logic                clk_sdram,
    input  logic                rst_n,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic                vid_ack,
    output logic                vid_rvalid,
    output logic [DATA_W-1:0]   vid_rdata,
    output logic                vid_done,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_ack,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_burst,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_wdone
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [15:0]         stat_vid_bursts,
    output logic [15:0]         stat_cpu_forced
`endif
);
    localparam int              BEAT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [7:0]      MAX_WAIT  = 8'(CPU_MAX_WAIT);

    typedef enum logic [2:0] {IDLE, ISSUE, CPU_WAIT, VID_STREAM, DONE} state_t;

    state_t              state;
    logic                owner_vid;
    logic [7:0]          wait_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                vid_wins;
    logic                cpu_wins;
    logic                cpu_owns;

    always_comb begin
        vid_wins = vid_req && (!cpu_req || (wait_cnt < MAX_WAIT));
        cpu_wins = !vid_wins && cpu_req;
        cpu_owns = !owner_vid && ((state == ISSUE) || (state == CPU_WAIT));
    end

    always_ff @(posedge clk_sdram or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_vid  <= 1'b0;
            wait_cnt   <= '0;
            beat_cnt   <= '0;
            vid_ack    <= 1'b0;
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
            vid_done   <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_burst  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
`ifdef SDRAM_ARB_STATS_EN
            stat_vid_bursts <= '0;
            stat_cpu_forced <= '0;
`endif
        end else begin
            vid_ack    <= 1'b0;
            vid_rvalid <= 1'b0;
            vid_done   <= 1'b0;
            cpu_ack    <= 1'b0;

            // CPU starvation accounting; a CPU win below overrides this with a clear
            if (cpu_req && !cpu_owns && (wait_cnt < MAX_WAIT))
                wait_cnt <= wait_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (vid_wins) begin
                        owner_vid <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_burst <= 1'b1;
                        mem_addr  <= vid_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                        state     <= ISSUE;
                    end else if (cpu_wins) begin
                        owner_vid <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_burst <= 1'b0;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_be    <= cpu_be;
                        wait_cnt  <= '0;
                        state     <= ISSUE;
`ifdef SDRAM_ARB_STATS_EN
                        if (vid_req && (stat_cpu_forced != 16'hFFFF))
                            stat_cpu_forced <= stat_cpu_forced + 16'd1;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (owner_vid) begin
                            vid_ack  <= 1'b1;
                            beat_cnt <= '0;
                            state    <= VID_STREAM;
                        end else begin
                            state    <= CPU_WAIT;
                        end
                    end
                end
                CPU_WAIT: begin
                    if (!mem_we && mem_rvalid) begin
                        cpu_rdata <= mem_rdata;
                        cpu_ack   <= 1'b1;
                        state     <= DONE;
                    end else if (mem_we && mem_wdone) begin
                        cpu_ack   <= 1'b1;
                        state     <= DONE;
                    end
                end
                VID_STREAM: begin
                    if (mem_rvalid) begin
                        vid_rvalid <= 1'b1;
                        vid_rdata  <= mem_rdata;
                        beat_cnt   <= beat_cnt + BEAT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            vid_done <= 1'b1;
                            state    <= DONE;
`ifdef SDRAM_ARB_STATS_EN
                            if (stat_vid_bursts != 16'hFFFF)
                                stat_vid_bursts <= stat_vid_bursts + 16'd1;
`endif
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: behavioural SDRAM controller plus scoreboard queues of expected read data and grant order.
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;

    logic              clk_sdram = 1'b0;
    logic              rst_n     = 1'b0;
    logic              vid_req   = 1'b0;
    logic [ADDR_W-1:0] vid_addr  = '0;
    logic              vid_ack, vid_rvalid, vid_done;
    logic [DATA_W-1:0] vid_rdata;
    logic              cpu_req   = 1'b0;
    logic              cpu_we    = 1'b0;
    logic [ADDR_W-1:0] cpu_addr  = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [3:0]        cpu_be    = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_req, mem_we, mem_burst;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_gnt    = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata  = '0;
    logic              mem_wdone  = 1'b0;
`ifdef SDRAM_ARB_STATS_EN
    logic [15:0]       stat_vid_bursts, stat_cpu_forced;
`endif

    sdram_port_arbiter dut (
        .clk_sdram(clk_sdram), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata), .vid_done(vid_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_burst(mem_burst), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wdone(mem_wdone)
`ifdef SDRAM_ARB_STATS_EN
        , .stat_vid_bursts(stat_vid_bursts), .stat_cpu_forced(stat_cpu_forced)
`endif
    );

    always #5 clk_sdram = ~clk_sdram;

    wire [128:0] all_outs = {vid_ack, vid_rvalid, vid_rdata, vid_done, cpu_ack, cpu_rdata,
                             mem_req, mem_we, mem_burst, mem_addr, mem_wdata, mem_be};

    int n_cmp = 0;
    int n_bad = 0;
    int exp_bursts = 0;
    int exp_forced = 0;

    logic [DATA_W-1:0] vid_q[$];
    logic [DATA_W-1:0] cpu_q[$];
    logic              ord_q[$];

    // controller knobs, written only by the test tasks
    int                gnt_dly = 1;
    int                rsp_dly = 1;
    logic [DATA_W-1:0] c_base = '0;
    logic [DATA_W-1:0] c_cpu_data = '0;
    int                spur_req = 0;

    int   spur_done = 0;
    int   cst = 0, cwait = 0, beats = 0;
    logic c_burst = 1'b0, c_we = 1'b0;

    // Controller model: acts on the falling edge so the DUT samples it on the next rising edge
    always @(negedge clk_sdram) begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_wdone = 1'b0;
        if (!rst_n) begin
            cst = 0;
            spur_done = spur_req;
            vid_q.delete();
            cpu_q.delete();
        end else if (spur_req != spur_done) begin
            spur_done  = spur_req;
            mem_gnt    = 1'b1;
            mem_rvalid = 1'b1;
            mem_wdone  = 1'b1;
            mem_rdata  = 32'hBAD0BAD0;
        end else begin
            if (cst == 0 && mem_req) begin cwait = gnt_dly; cst = 1; end
            if (cst == 1) begin
                cwait--;
                if (cwait == 0) begin
                    mem_gnt = 1'b1; c_burst = mem_burst; c_we = mem_we;
                    cwait = rsp_dly; cst = 2;
                end
            end else if (cst == 2) begin
                cwait--;
                if (cwait == 0) begin cst = 3; beats = 0; end
            end
            if (cst == 3) begin
                if (c_we) begin
                    mem_wdone = 1'b1; cst = 0;
                end else begin
                    mem_rvalid = 1'b1;
                    if (c_burst) begin mem_rdata = c_base + 32'(beats); vid_q.push_back(mem_rdata); end
                    else begin mem_rdata = c_cpu_data; cpu_q.push_back(mem_rdata); end
                    beats++;
                    if (!c_burst || beats == 8) cst = 0;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sdram);
        n_cmp++;
        if (all_outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
`ifdef SDRAM_ARB_STATS_EN
        n_cmp++;
        if ({stat_vid_bursts, stat_cpu_forced} !== 32'h0) begin
            n_bad++; $display("FAIL reset_stats: got %h/%h want 0/0", stat_vid_bursts, stat_cpu_forced);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sdram);
        n_cmp++;
        if (all_outs !== '0) begin n_bad++; $display("FAIL idle_after_reset: got %h want 0", all_outs); end
    endtask

    task automatic test_cpu_read();
        bit got = 0;
        logic [DATA_W-1:0] exp;
        gnt_dly = 2; rsp_dly = 3; c_cpu_data = 32'hDEADBEEF;
        cpu_we = 1'b0; cpu_addr = 22'h000123; cpu_be = 4'hF; cpu_wdata = '0; cpu_req = 1'b1;
        @(negedge clk_sdram);
        n_cmp++;
        if ({mem_req, mem_we, mem_burst} !== 3'b100) begin
            n_bad++; $display("FAIL rd_issue: req/we/burst got %b want 100", {mem_req, mem_we, mem_burst});
        end
        n_cmp++;
        if (mem_addr !== 22'h000123) begin n_bad++; $display("FAIL rd_addr: got %h want 000123", mem_addr); end
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk_sdram);
            if (i == 1) begin
                n_cmp++;
                if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rd_req_hold: got %b want 1", mem_req); end
            end
            if (i == 2) begin
                n_cmp++;
                if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rd_req_drop: got %b want 0", mem_req); end
            end
            if (cpu_ack) begin
                got = 1; cpu_req = 1'b0;
                n_cmp++;
                if (i != 5) begin n_bad++; $display("FAIL rd_ack_latency: got %0d want 5", i); end
                exp = (cpu_q.size() > 0) ? cpu_q.pop_front() : 'x;
                n_cmp++;
                if (cpu_rdata !== exp) begin n_bad++; $display("FAIL rd_data: got %h want %h", cpu_rdata, exp); end
            end
        end
        if (!got) begin n_cmp++; n_bad++; $display("FAIL rd_ack_timeout: got none want cpu_ack"); end
        @(negedge clk_sdram);
        n_cmp++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL rd_ack_pulse: ack %b data %h want 0 deadbeef", cpu_ack, cpu_rdata);
        end
        @(negedge clk_sdram);
    endtask

    task automatic test_cpu_write();
        bit got = 0;
        gnt_dly = 1; rsp_dly = 2;
        cpu_we = 1'b1; cpu_addr = 22'h0002AA; cpu_be = 4'b0011; cpu_wdata = 32'h12345678; cpu_req = 1'b1;
        @(negedge clk_sdram);
        n_cmp++;
        if ({mem_req, mem_we, mem_burst, mem_be} !== 7'b110_0011 || mem_wdata !== 32'h12345678) begin
            n_bad++; $display("FAIL wr_issue: req/we/burst/be %b data %h want 1100011 12345678",
                              {mem_req, mem_we, mem_burst, mem_be}, mem_wdata);
        end
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk_sdram);
            if (cpu_ack) begin
                got = 1; cpu_req = 1'b0;
                n_cmp++;
                if (i != 3) begin n_bad++; $display("FAIL wr_ack_latency: got %0d want 3", i); end
                n_cmp++;
                if (cpu_rdata !== 32'hDEADBEEF) begin
                    n_bad++; $display("FAIL wr_rdata_held: got %h want deadbeef", cpu_rdata);
                end
            end
        end
        if (!got) begin n_cmp++; n_bad++; $display("FAIL wr_ack_timeout: got none want cpu_ack"); end
        repeat (2) @(negedge clk_sdram);
        cpu_we = 1'b0;
    endtask

    // Runs both requesters against the controller model, checking grant order and every returned word
    task automatic run_mixed(input string tag, input int n_bursts, input int max_cyc);
        logic prev_req = 1'b0;
        logic exp_b;
        logic [DATA_W-1:0] exp;
        int vb = 0, acks = 0, dones = 0, cpu_done = 0, done_cyc = -1000;
        for (int i = 0; i < max_cyc && !(dones == n_bursts && cpu_done == 1); i++) begin
            @(negedge clk_sdram);
            if (mem_req && !prev_req) begin
                exp_b = (ord_q.size() > 0) ? ord_q.pop_front() : 1'bx;
                n_cmp++;
                if (mem_burst !== exp_b) begin n_bad++; $display("FAIL %s_order: burst got %b want %b", tag, mem_burst, exp_b); end
                if (mem_burst) begin
                    n_cmp++;
                    if (mem_addr !== vid_addr || mem_be !== 4'hF || mem_we !== 1'b0) begin
                        n_bad++; $display("FAIL %s_burst_fields: addr %h be %b we %b want %h 1111 0", tag, mem_addr, mem_be, mem_we, vid_addr);
                    end
                end else if (n_bursts == 1) begin
                    n_cmp++;
                    if (i - done_cyc != 2) begin n_bad++; $display("FAIL %s_cpu_after_done: gap %0d want 2", tag, i - done_cyc); end
                end
            end
            prev_req = mem_req;
            if (vid_ack) begin acks++; if (acks == n_bursts) vid_req = 1'b0; end
            if (vid_rvalid) begin
                vb++;
                exp = (vid_q.size() > 0) ? vid_q.pop_front() : 'x;
                n_cmp++;
                if (vid_rdata !== exp) begin n_bad++; $display("FAIL %s_vid_data: got %h want %h", tag, vid_rdata, exp); end
                n_cmp++;
                if (vid_done !== ((vb % 8) == 0)) begin n_bad++; $display("FAIL %s_vid_done_pos: got %b at beat %0d", tag, vid_done, vb); end
                if (vid_done) begin dones++; done_cyc = i; end
            end
            if (cpu_ack) begin
                cpu_req = 1'b0; cpu_done++;
                exp = (cpu_q.size() > 0) ? cpu_q.pop_front() : 'x;
                n_cmp++;
                if (cpu_rdata !== exp) begin n_bad++; $display("FAIL %s_cpu_data: got %h want %h", tag, cpu_rdata, exp); end
            end
        end
        n_cmp++;
        if (dones != n_bursts || cpu_done != 1 || vb != 8 * n_bursts || ord_q.size() != 0) begin
            n_bad++; $display("FAIL %s_complete: bursts %0d cpu %0d beats %0d left %0d want %0d 1 %0d 0",
                              tag, dones, cpu_done, vb, ord_q.size(), n_bursts, 8 * n_bursts);
        end
        exp_bursts += n_bursts;
        repeat (2) @(negedge clk_sdram);
    endtask

    task automatic test_vid_priority();
        gnt_dly = 1; rsp_dly = 1; c_base = 32'h0; c_cpu_data = 32'h0BADF00D;
        ord_q.delete(); ord_q.push_back(1'b1); ord_q.push_back(1'b0);
        vid_addr = 22'h100000; vid_req = 1'b1;
        cpu_we = 1'b0; cpu_addr = 22'h000055; cpu_be = 4'hF; cpu_req = 1'b1;
        run_mixed("prio", 1, 100);
    endtask

    task automatic test_starvation();
        gnt_dly = 1; rsp_dly = 1; c_base = 32'h0000A000; c_cpu_data = 32'h5A5A0001;
        ord_q.delete();
        ord_q.push_back(1'b1); ord_q.push_back(1'b1); ord_q.push_back(1'b0); ord_q.push_back(1'b1);
        vid_addr = 22'h0ABCD0; vid_req = 1'b1;
        cpu_we = 1'b0; cpu_addr = 22'h000777; cpu_be = 4'hF; cpu_req = 1'b1;
        exp_forced++;
        run_mixed("starve", 3, 200);
`ifdef SDRAM_ARB_STATS_EN
        n_cmp++;
        if (stat_cpu_forced !== 16'(exp_forced) || stat_vid_bursts !== 16'(exp_bursts)) begin
            n_bad++; $display("FAIL stats: forced %0d bursts %0d want %0d %0d", stat_cpu_forced, stat_vid_bursts, exp_forced, exp_bursts);
        end
`endif
    endtask

    task automatic test_spurious();
        bit got = 0;
        spur_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sdram);
            n_cmp++;
            if ({vid_ack, vid_rvalid, vid_done, cpu_ack, mem_req} !== 5'b0) begin
                n_bad++; $display("FAIL spurious_quiet: ack/rv/done/cack/req got %b want 00000",
                                  {vid_ack, vid_rvalid, vid_done, cpu_ack, mem_req});
            end
        end
        gnt_dly = 1; rsp_dly = 1; c_cpu_data = 32'h13579BDF;
        cpu_we = 1'b0; cpu_addr = 22'h000042; cpu_be = 4'hF; cpu_req = 1'b1;
        @(negedge clk_sdram);
        n_cmp++;
        if (mem_req !== 1'b1) begin n_bad++; $display("FAIL spurious_then_issue: mem_req got %b want 1", mem_req); end
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk_sdram);
            if (cpu_ack) begin
                got = 1; cpu_req = 1'b0;
                n_cmp++;
                if (i != 2 || cpu_rdata !== 32'h13579BDF) begin
                    n_bad++; $display("FAIL spurious_then_read: lat %0d data %h want 2 13579bdf", i, cpu_rdata);
                end
            end
        end
        if (!got) begin n_cmp++; n_bad++; $display("FAIL spurious_read_timeout: got none want cpu_ack"); end
        repeat (2) @(negedge clk_sdram);
    endtask

    task automatic test_reset_mid_burst();
        bit got = 0;
        int vb = 0, stray = 0;
        logic [DATA_W-1:0] exp;
        gnt_dly = 1; rsp_dly = 1; c_base = 32'h00000100;
        vid_addr = 22'h3F0000; vid_req = 1'b1;
        for (int i = 0; i < 40 && vb < 3; i++) begin
            @(negedge clk_sdram);
            if (vid_ack) vid_req = 1'b0;
            if (vid_rvalid) begin
                vb++;
                exp = (vid_q.size() > 0) ? vid_q.pop_front() : 'x;
                n_cmp++;
                if (vid_rdata !== exp) begin n_bad++; $display("FAIL rstmid_data: got %h want %h", vid_rdata, exp); end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (vb != 3 || all_outs !== '0) begin
            n_bad++; $display("FAIL rstmid_async_clear: beats %0d outs %h want 3 0", vb, all_outs);
        end
`ifdef SDRAM_ARB_STATS_EN
        n_cmp++;
        if ({stat_vid_bursts, stat_cpu_forced} !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_stats: got %h/%h want 0/0", stat_vid_bursts, stat_cpu_forced);
        end
`endif
        vid_req = 1'b0;
        repeat (2) @(negedge clk_sdram);
        rst_n = 1'b1;
        @(negedge clk_sdram);
        c_cpu_data = 32'hCAFEF00D;
        cpu_we = 1'b0; cpu_addr = 22'h000321; cpu_be = 4'hF; cpu_req = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk_sdram);
            if (vid_rvalid) stray++;
            if (cpu_ack) begin
                got = 1; cpu_req = 1'b0;
                exp = (cpu_q.size() > 0) ? cpu_q.pop_front() : 'x;
                n_cmp++;
                if (cpu_rdata !== exp || exp !== 32'hCAFEF00D) begin
                    n_bad++; $display("FAIL rstmid_cpu_read: got %h want cafef00d", cpu_rdata);
                end
            end
        end
        if (!got) begin n_cmp++; n_bad++; $display("FAIL rstmid_cpu_timeout: got none want cpu_ack"); end
        repeat (3) @(negedge clk_sdram);
        n_cmp++;
        if (stray != 0) begin n_bad++; $display("FAIL rstmid_stray_vid: got %0d want 0", stray); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_vid_priority();
        test_starvation();
        test_spurious();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
